// File: rtl/spi_frame_scheduler.sv
// ============================================================================
// Module   : spi_frame_scheduler
// Purpose  : SPI slave transmit sequencer: decodes host commands, snapshots
//            pose/distance telemetry and streams it one byte per rx event.
//            Optional XOR checksum byte: define SPI_FRAME_SCHEDULER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_scheduler #(
    parameter int         N_WIDTH      = 17,
    parameter int         PULSE_CYCLES = 4,
    parameter logic [7:0] IDLE_BYTE    = 8'h5A,
    parameter logic [7:0] ERR_BYTE     = 8'hEE
) (
    input  logic               SPI_FRAME_SCHEDULER_CLOCK_50,
    input  logic               SPI_FRAME_SCHEDULER_RESET_InLow,
    input  logic               SPI_FRAME_SCHEDULER_SS_InLow,
    input  logic               SPI_FRAME_SCHEDULER_NEWDATA_In,
    input  logic [7:0]         SPI_FRAME_SCHEDULER_DATAIN_InBus,
    input  logic [N_WIDTH-1:0] SPI_FRAME_SCHEDULER_POSX_InBus,
    input  logic [N_WIDTH-1:0] SPI_FRAME_SCHEDULER_POSY_InBus,
    input  logic [N_WIDTH-1:0] SPI_FRAME_SCHEDULER_THETA_InBus,
    input  logic [N_WIDTH-1:0] SPI_FRAME_SCHEDULER_DIST1_InBus,
    input  logic [N_WIDTH-1:0] SPI_FRAME_SCHEDULER_DIST2_InBus,
    input  logic [N_WIDTH-1:0] SPI_FRAME_SCHEDULER_DIST3_InBus,
    input  logic [N_WIDTH-1:0] SPI_FRAME_SCHEDULER_DIST4_InBus,
    output logic [7:0]         SPI_FRAME_SCHEDULER_DATAOUT_OutBus,
    output logic [2:0]         SPI_FRAME_SCHEDULER_WAYSELECT_OutBus,
    output logic               SPI_FRAME_SCHEDULER_STOPSIGNAL_OutLow,
    output logic               SPI_FRAME_SCHEDULER_BEGINSIGNAL_OutLow,
    output logic               SPI_FRAME_SCHEDULER_BUSY_Out
);

    localparam int                 c_CNT_W      = $clog2(PULSE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_PULSE_LOAD = c_CNT_W'(PULSE_CYCLES);
    localparam logic [3:0]         c_POSE_LAST  = 4'd8;
    localparam logic [3:0]         c_DIST_LAST  = 4'd11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_CKSUM  = 2'd2,
        S_ERR    = 2'd3
    } state_t;

    function automatic logic [23:0] f_ext24(input logic [N_WIDTH-1:0] v);
        logic [23:0] r;
        r            = '0;
        r[N_WIDTH-1:0] = v;
        return r;
    endfunction

    state_t             r_state;
    state_t             w_state_nx;
    logic [3:0]         r_idx;
    logic               r_is_dist;
    logic [7:0]         r_snap [0:11];
    logic [7:0]         r_dataout;
    logic [2:0]         r_waysel;
    logic [c_CNT_W-1:0] r_stop_cnt;
    logic [c_CNT_W-1:0] r_begin_cnt;
    logic               r_ss_d;
`ifdef SPI_FRAME_SCHEDULER_CHECKSUM_EN
    logic [7:0]         r_cksum;
    logic               w_to_cksum;
`endif

    logic [7:0]  w_load [0:11];
    logic [23:0] w_posx, w_posy, w_theta, w_d1, w_d2, w_d3, w_d4;
    logic [3:0]  w_idx_nx;
    logic [7:0]  w_next_byte;
    logic        w_last;
    logic        w_abort;
    logic        w_go_idle;
    logic        w_accept_pose;
    logic        w_accept_dist;
    logic        w_advance;
    logic        w_to_err;
    logic        w_cmd_way;
    logic        w_cmd_stop;
    logic        w_cmd_begin;

    assign w_posx  = f_ext24(SPI_FRAME_SCHEDULER_POSX_InBus);
    assign w_posy  = f_ext24(SPI_FRAME_SCHEDULER_POSY_InBus);
    assign w_theta = f_ext24(SPI_FRAME_SCHEDULER_THETA_InBus);
    assign w_d1    = f_ext24(SPI_FRAME_SCHEDULER_DIST1_InBus);
    assign w_d2    = f_ext24(SPI_FRAME_SCHEDULER_DIST2_InBus);
    assign w_d3    = f_ext24(SPI_FRAME_SCHEDULER_DIST3_InBus);
    assign w_d4    = f_ext24(SPI_FRAME_SCHEDULER_DIST4_InBus);

    assign w_idx_nx    = r_idx + 4'd1;
    assign w_next_byte = r_snap[w_idx_nx];
    assign w_last      = (r_idx == (r_is_dist ? c_DIST_LAST : c_POSE_LAST));
    assign w_abort     = SPI_FRAME_SCHEDULER_SS_InLow && !r_ss_d && (r_state != S_IDLE);

    // Snapshot source: pose frames leave the three tail bytes zero.
    always_comb begin
        for (int i = 0; i < 12; i++) w_load[i] = 8'h00;
        if (w_accept_pose) begin
            {w_load[0], w_load[1], w_load[2]} = w_posx;
            {w_load[3], w_load[4], w_load[5]} = w_posy;
            {w_load[6], w_load[7], w_load[8]} = w_theta;
        end else begin
            {w_load[0], w_load[1], w_load[2]}   = w_d1;
            {w_load[3], w_load[4], w_load[5]}   = w_d2;
            {w_load[6], w_load[7], w_load[8]}   = w_d3;
            {w_load[9], w_load[10], w_load[11]} = w_d4;
        end
    end

    always_ff @(posedge SPI_FRAME_SCHEDULER_CLOCK_50 or negedge SPI_FRAME_SCHEDULER_RESET_InLow) begin
        if (!SPI_FRAME_SCHEDULER_RESET_InLow) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx    = r_state;
        w_go_idle     = 1'b0;
        w_accept_pose = 1'b0;
        w_accept_dist = 1'b0;
        w_advance     = 1'b0;
        w_to_err      = 1'b0;
        w_cmd_way     = 1'b0;
        w_cmd_stop    = 1'b0;
        w_cmd_begin   = 1'b0;
`ifdef SPI_FRAME_SCHEDULER_CHECKSUM_EN
        w_to_cksum    = 1'b0;
`endif
        if (w_abort) begin
            w_state_nx = S_IDLE;
            w_go_idle  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (SPI_FRAME_SCHEDULER_NEWDATA_In) begin
                        if (SPI_FRAME_SCHEDULER_DATAIN_InBus == 8'hA1) begin
                            w_accept_pose = 1'b1;
                            w_state_nx    = S_STREAM;
                        end else if (SPI_FRAME_SCHEDULER_DATAIN_InBus == 8'hA2) begin
                            w_accept_dist = 1'b1;
                            w_state_nx    = S_STREAM;
                        end else if (SPI_FRAME_SCHEDULER_DATAIN_InBus[7:3] == 5'b10110) begin
                            w_cmd_way = 1'b1;
                        end else if (SPI_FRAME_SCHEDULER_DATAIN_InBus == 8'hC0) begin
                            w_cmd_stop = 1'b1;
                        end else if (SPI_FRAME_SCHEDULER_DATAIN_InBus == 8'hC1) begin
                            w_cmd_begin = 1'b1;
                        end else if (SPI_FRAME_SCHEDULER_DATAIN_InBus != 8'h00) begin
                            w_to_err   = 1'b1;
                            w_state_nx = S_ERR;
                        end
                    end
                end
                S_STREAM: begin
                    if (SPI_FRAME_SCHEDULER_NEWDATA_In) begin
                        if (w_last) begin
`ifdef SPI_FRAME_SCHEDULER_CHECKSUM_EN
                            w_to_cksum = 1'b1;
                            w_state_nx = S_CKSUM;
`else
                            w_go_idle  = 1'b1;
                            w_state_nx = S_IDLE;
`endif
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                end
                S_CKSUM, S_ERR: begin
                    if (SPI_FRAME_SCHEDULER_NEWDATA_In) begin
                        w_go_idle  = 1'b1;
                        w_state_nx = S_IDLE;
                    end
                end
                default: begin
                    w_go_idle  = 1'b1;
                    w_state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge SPI_FRAME_SCHEDULER_CLOCK_50 or negedge SPI_FRAME_SCHEDULER_RESET_InLow) begin
        if (!SPI_FRAME_SCHEDULER_RESET_InLow) begin
            r_idx       <= 4'd0;
            r_is_dist   <= 1'b0;
            r_dataout   <= IDLE_BYTE;
            r_waysel    <= 3'd0;
            r_stop_cnt  <= '0;
            r_begin_cnt <= '0;
            r_ss_d      <= 1'b1;
            for (int i = 0; i < 12; i++) r_snap[i] <= 8'h00;
`ifdef SPI_FRAME_SCHEDULER_CHECKSUM_EN
            r_cksum     <= 8'h00;
`endif
        end else begin
            r_ss_d <= SPI_FRAME_SCHEDULER_SS_InLow;

            // A repeated command reloads the counter, stretching the pulse.
            if (w_cmd_stop) begin
                r_stop_cnt <= c_PULSE_LOAD;
            end else if (r_stop_cnt != '0) begin
                r_stop_cnt <= r_stop_cnt - 1'b1;
            end
            if (w_cmd_begin) begin
                r_begin_cnt <= c_PULSE_LOAD;
            end else if (r_begin_cnt != '0) begin
                r_begin_cnt <= r_begin_cnt - 1'b1;
            end

            if (w_cmd_way) begin
                r_waysel <= SPI_FRAME_SCHEDULER_DATAIN_InBus[2:0];
            end

            if (w_go_idle) begin
                r_dataout <= IDLE_BYTE;
                r_idx     <= 4'd0;
`ifdef SPI_FRAME_SCHEDULER_CHECKSUM_EN
                r_cksum   <= 8'h00;
`endif
            end else if (w_accept_pose || w_accept_dist) begin
                for (int i = 0; i < 12; i++) r_snap[i] <= w_load[i];
                r_is_dist <= w_accept_dist;
                r_idx     <= 4'd0;
                r_dataout <= w_load[0];
`ifdef SPI_FRAME_SCHEDULER_CHECKSUM_EN
                r_cksum   <= w_load[0];
`endif
            end else if (w_advance) begin
                r_idx     <= w_idx_nx;
                r_dataout <= w_next_byte;
`ifdef SPI_FRAME_SCHEDULER_CHECKSUM_EN
                r_cksum   <= r_cksum ^ w_next_byte;
`endif
`ifdef SPI_FRAME_SCHEDULER_CHECKSUM_EN
            end else if (w_to_cksum) begin
                r_dataout <= r_cksum;
`endif
            end else if (w_to_err) begin
                r_dataout <= ERR_BYTE;
            end
        end
    end

    assign SPI_FRAME_SCHEDULER_DATAOUT_OutBus     = r_dataout;
    assign SPI_FRAME_SCHEDULER_WAYSELECT_OutBus   = r_waysel;
    assign SPI_FRAME_SCHEDULER_STOPSIGNAL_OutLow  = (r_stop_cnt == '0);
    assign SPI_FRAME_SCHEDULER_BEGINSIGNAL_OutLow = (r_begin_cnt == '0);
    assign SPI_FRAME_SCHEDULER_BUSY_Out           = (r_state == S_STREAM) || (r_state == S_CKSUM);

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_scheduler.sv
// ============================================================================
// Module   : tb_spi_frame_scheduler
// Purpose  : Self-checking bench for spi_frame_scheduler (command table,
//            frame streaming, strobes, abort, reset). Follows the
//            SPI_FRAME_SCHEDULER_CHECKSUM_EN setting of the design build.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_frame_scheduler;

    localparam int NW = 17;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          ss_n  = 1'b1;
    logic          nd    = 1'b0;
    logic [7:0]    din   = 8'h00;
    logic [NW-1:0] posx  = '0, posy = '0, theta = '0;
    logic [NW-1:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    logic [7:0]    dout;
    logic [2:0]    way;
    logic          stop_n, begin_n, busy;

    spi_frame_scheduler #(.N_WIDTH(NW)) dut (
        .SPI_FRAME_SCHEDULER_CLOCK_50          (clk),
        .SPI_FRAME_SCHEDULER_RESET_InLow       (rst_n),
        .SPI_FRAME_SCHEDULER_SS_InLow          (ss_n),
        .SPI_FRAME_SCHEDULER_NEWDATA_In        (nd),
        .SPI_FRAME_SCHEDULER_DATAIN_InBus      (din),
        .SPI_FRAME_SCHEDULER_POSX_InBus        (posx),
        .SPI_FRAME_SCHEDULER_POSY_InBus        (posy),
        .SPI_FRAME_SCHEDULER_THETA_InBus       (theta),
        .SPI_FRAME_SCHEDULER_DIST1_InBus       (d1),
        .SPI_FRAME_SCHEDULER_DIST2_InBus       (d2),
        .SPI_FRAME_SCHEDULER_DIST3_InBus       (d3),
        .SPI_FRAME_SCHEDULER_DIST4_InBus       (d4),
        .SPI_FRAME_SCHEDULER_DATAOUT_OutBus    (dout),
        .SPI_FRAME_SCHEDULER_WAYSELECT_OutBus  (way),
        .SPI_FRAME_SCHEDULER_STOPSIGNAL_OutLow (stop_n),
        .SPI_FRAME_SCHEDULER_BEGINSIGNAL_OutLow(begin_n),
        .SPI_FRAME_SCHEDULER_BUSY_Out          (busy)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Low-cycle tallies of the strobes, sampled away from the active edge.
    int stop_lows = 0, begin_lows = 0, both_lows = 0;
    always @(negedge clk) begin
        if (!stop_n) stop_lows++;
        if (!begin_n) begin_lows++;
        if (!stop_n && !begin_n) both_lows++;
    end

    typedef struct {
        logic [7:0] tx;
        logic       busy;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        logic       busy;
        logic [2:0] way;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One rx byte event; called and returns on a falling edge.
    task automatic xfer(input logic [7:0] b, input logic [7:0] exp_tx, input logic exp_busy,
                        input string name);
        exp_t e;
        sb_q.push_back('{tx: exp_tx, busy: exp_busy});
        nd  = 1'b1;
        din = b;
        @(negedge clk);
        nd  = 1'b0;
        din = 8'h00;
        e = sb_q.pop_front();
        check({name, " tx"}, {24'h0, dout}, {24'h0, e.tx});
        check({name, " busy"}, {31'h0, busy}, {31'h0, e.busy});
    endtask

    logic [7:0] pose_exp [0:8];
    logic [7:0] dist_exp [0:11];
    logic [7:0] cks;
    int         base_s, base_b, base_both;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{rx: 8'hB5, tx: 8'h5A, busy: 1'b0, way: 3'd5};
        vecs[1] = '{rx: 8'h00, tx: 8'h5A, busy: 1'b0, way: 3'd5};
        vecs[2] = '{rx: 8'hB0, tx: 8'h5A, busy: 1'b0, way: 3'd0};
        vecs[3] = '{rx: 8'hB7, tx: 8'h5A, busy: 1'b0, way: 3'd7};
        vecs[4] = '{rx: 8'h77, tx: 8'hEE, busy: 1'b0, way: 3'd7};
        vecs[5] = '{rx: 8'hA1, tx: 8'h5A, busy: 1'b0, way: 3'd7};
        vecs[6] = '{rx: 8'hFF, tx: 8'hEE, busy: 1'b0, way: 3'd7};
        vecs[7] = '{rx: 8'hB3, tx: 8'h5A, busy: 1'b0, way: 3'd7};
        vecs[8] = '{rx: 8'hB3, tx: 8'h5A, busy: 1'b0, way: 3'd3};
        vecs[9] = '{rx: 8'hA3, tx: 8'hEE, busy: 1'b0, way: 3'd3};

        pose_exp = '{8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'hFF, 8'h01, 8'h00, 8'h00};
        dist_exp = '{8'h01, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h01,
                     8'h01, 8'h02, 8'h03, 8'h00, 8'hF0, 8'hF0};

        // Reset
        repeat (3) @(negedge clk);
        check("reset dout", {24'h0, dout}, 32'h5A);
        check("reset way", {29'h0, way}, 32'h0);
        check("reset stop", {31'h0, stop_n}, 32'h1);
        check("reset begin", {31'h0, begin_n}, 32'h1);
        check("reset busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        ss_n  = 1'b0;
        @(negedge clk);

        // Command table
        for (int i = 0; i < 10; i++) begin
            xfer(vecs[i].rx, vecs[i].tx, vecs[i].busy, $sformatf("vec%0d", i));
            check($sformatf("vec%0d way", i), {29'h0, way}, {29'h0, vecs[i].way});
        end
        xfer(8'h00, 8'h5A, 1'b0, "err exit");

        // Pose frame; inputs change after accept must not leak into the frame
        posx  = 17'h12345;
        posy  = 17'h000FF;
        theta = 17'h10000;
        xfer(8'hA1, pose_exp[0], 1'b1, "pose b0");
        posx  = 17'h0ABCD;
        theta = 17'h1FFFF;
        for (int i = 1; i < 9; i++) xfer(8'h00, pose_exp[i], 1'b1, $sformatf("pose b%0d", i));
`ifdef SPI_FRAME_SCHEDULER_CHECKSUM_EN
        xfer(8'h00, 8'h99, 1'b1, "pose cksum");
`endif
        xfer(8'h00, 8'h5A, 1'b0, "pose end");
        xfer(8'hB2, 8'h5A, 1'b0, "way2");
        check("way2 value", {29'h0, way}, 32'd2);

        // Distance frame with command-looking fillers, which must not be decoded
        d1 = 17'h1ABCD; d2 = 17'h00001; d3 = 17'h10203; d4 = 17'h0F0F0;
        cks = 8'h00;
        for (int i = 0; i < 12; i++) cks = cks ^ dist_exp[i];
        base_s = stop_lows;
        xfer(8'hA2, dist_exp[0], 1'b1, "dist b0");
        for (int i = 1; i < 12; i++) xfer(8'hC0, dist_exp[i], 1'b1, $sformatf("dist b%0d", i));
`ifdef SPI_FRAME_SCHEDULER_CHECKSUM_EN
        xfer(8'hC0, cks, 1'b1, "dist cksum");
`endif
        xfer(8'hC0, 8'h5A, 1'b0, "dist end");
        repeat (6) @(negedge clk);
        check("no stop in frame", stop_lows - base_s, 0);

        // Abort coincident with NEWDATA, then restart at DIST1 byte 0
        xfer(8'hA2, dist_exp[0], 1'b1, "ab b0");
        for (int i = 1; i < 4; i++) xfer(8'h00, dist_exp[i], 1'b1, $sformatf("ab b%0d", i));
        ss_n = 1'b1;
        xfer(8'h00, 8'h5A, 1'b0, "abort nd");
        ss_n = 1'b0;
        xfer(8'hA2, dist_exp[0], 1'b1, "restart b0");
        xfer(8'h00, dist_exp[1], 1'b1, "restart b1");
        ss_n = 1'b1;
        @(negedge clk);
        check("abort idle dout", {24'h0, dout}, 32'h5A);
        check("abort idle busy", {31'h0, busy}, 32'h0);
        check("abort keeps way", {29'h0, way}, 32'd2);
        ss_n = 1'b0;
        @(negedge clk);

        // STOP pulse width, then restart on its second low clock
        base_s = stop_lows;
        xfer(8'hC0, 8'h5A, 1'b0, "stop cmd");
        repeat (8) @(negedge clk);
        check("stop width", stop_lows - base_s, 4);
        base_s = stop_lows;
        xfer(8'hC0, 8'h5A, 1'b0, "stop cmd a");
        @(negedge clk);
        xfer(8'hC0, 8'h5A, 1'b0, "stop cmd b");
        repeat (8) @(negedge clk);
        check("stop restart width", stop_lows - base_s, 6);

        // Overlapping STOP and BEGIN
        base_s = stop_lows; base_b = begin_lows; base_both = both_lows;
        xfer(8'hC0, 8'h5A, 1'b0, "ovl stop");
        xfer(8'hC1, 8'h5A, 1'b0, "ovl begin");
        repeat (8) @(negedge clk);
        check("ovl stop width", stop_lows - base_s, 4);
        check("ovl begin width", begin_lows - base_b, 4);
        check("ovl overlap", both_lows - base_both, 3);

        // Asynchronous reset mid-frame
        xfer(8'hA1, 8'h00, 1'b1, "pre-reset b0");
        #3 rst_n = 1'b0;
        #1;
        check("midreset dout", {24'h0, dout}, 32'h5A);
        check("midreset busy", {31'h0, busy}, 32'h0);
        check("midreset way", {29'h0, way}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xfer(8'h00, 8'h5A, 1'b0, "post-reset idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
